// File: rtl/wb_port_scheduler_if.sv
// Shared width package and the handshake/bus interface for wb_port_scheduler.
// The master modport drives requests and reads grants; the slave modport is the scheduler.
package params_pkg;
  localparam int REGISTER_WIDTH = 5;
endpackage

interface wb_port_scheduler_if #(
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) ();
  logic                      ex_issue_i;
  logic [REGISTER_WIDTH-1:0] ex_issue_wr_reg_i;
  logic                      mem_wb_req_i;
  logic [REGISTER_WIDTH-1:0] mem_wr_reg_i;
  logic                      alu_wb_req_i;
  logic [REGISTER_WIDTH-1:0] alu_wr_reg_i;
  logic                      ex_allowed_wb_o;
  logic                      alu_allowed_wb_o;
  logic                      wb_is_next_cycle_o;
  logic                      rf_wr_en_o;
  logic [REGISTER_WIDTH-1:0] rf_wr_reg_o;
  logic [1:0]                rf_wr_src_o;
  logic                      err_o;
  logic [31:0]               ex_conflict_cnt_o;
  logic [31:0]               alu_conflict_cnt_o;

  modport master (
    output ex_issue_i, ex_issue_wr_reg_i, mem_wb_req_i, mem_wr_reg_i,
           alu_wb_req_i, alu_wr_reg_i,
    input  ex_allowed_wb_o, alu_allowed_wb_o, wb_is_next_cycle_o, rf_wr_en_o,
           rf_wr_reg_o, rf_wr_src_o, err_o, ex_conflict_cnt_o, alu_conflict_cnt_o
  );

  modport slave (
    input  ex_issue_i, ex_issue_wr_reg_i, mem_wb_req_i, mem_wr_reg_i,
           alu_wb_req_i, alu_wr_reg_i,
    output ex_allowed_wb_o, alu_allowed_wb_o, wb_is_next_cycle_o, rf_wr_en_o,
           rf_wr_reg_o, rf_wr_src_o, err_o, ex_conflict_cnt_o, alu_conflict_cnt_o
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// Register-file write-port arbiter: MEM > EX (reserved at issue) > ALU.
// Optional conflict counters are built when WB_SCHED_STATS_EN is defined.
module wb_port_scheduler #(
  parameter int EX_LATENCY     = 5,
  parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_port_scheduler_if.slave bus
);
  logic [EX_LATENCY-1:0]                     res_q;
  logic [EX_LATENCY-1:0][REGISTER_WIDTH-1:0] reg_q;
  logic                                      err_q;
  logic                                      freeze;
  logic                                      alu_allowed;

  assign freeze      = res_q[0] & bus.mem_wb_req_i;
  assign alu_allowed = !bus.mem_wb_req_i & !res_q[0];

  assign bus.ex_allowed_wb_o    = res_q[0] & !bus.mem_wb_req_i;
  assign bus.alu_allowed_wb_o   = alu_allowed;
  // A stalled EX result stays in slot 0 and retries next cycle.
  assign bus.wb_is_next_cycle_o = freeze ? res_q[0] : res_q[1];
  assign bus.err_o              = err_q;

  always_comb begin
    bus.rf_wr_en_o  = 1'b0;
    bus.rf_wr_reg_o = '0;
    bus.rf_wr_src_o = 2'd0;
    if (bus.mem_wb_req_i) begin
      bus.rf_wr_en_o  = 1'b1;
      bus.rf_wr_reg_o = bus.mem_wr_reg_i;
      bus.rf_wr_src_o = 2'd1;
    end else if (res_q[0]) begin
      bus.rf_wr_en_o  = 1'b1;
      bus.rf_wr_reg_o = reg_q[0];
      bus.rf_wr_src_o = 2'd2;
    end else if (bus.alu_wb_req_i) begin
      bus.rf_wr_en_o  = 1'b1;
      bus.rf_wr_reg_o = bus.alu_wr_reg_i;
      bus.rf_wr_src_o = 2'd3;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_q <= '0;
      reg_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!freeze) begin
        res_q <= {bus.ex_issue_i, res_q[EX_LATENCY-1:1]};
        reg_q <= {bus.ex_issue_wr_reg_i, reg_q[EX_LATENCY-1:1]};
      end
      // Issue while EX is stalled is dropped and flagged.
      if (freeze && bus.ex_issue_i) err_q <= 1'b1;
    end
  end

`ifdef WB_SCHED_STATS_EN
  logic [31:0] ex_cnt_q, alu_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_cnt_q  <= '0;
      alu_cnt_q <= '0;
    end else begin
      if (freeze && ex_cnt_q != 32'hFFFF_FFFF) ex_cnt_q <= ex_cnt_q + 32'd1;
      if (bus.alu_wb_req_i && !alu_allowed && alu_cnt_q != 32'hFFFF_FFFF)
        alu_cnt_q <= alu_cnt_q + 32'd1;
    end
  end

  assign bus.ex_conflict_cnt_o  = ex_cnt_q;
  assign bus.alu_conflict_cnt_o = alu_cnt_q;
`else
  assign bus.ex_conflict_cnt_o  = '0;
  assign bus.alu_conflict_cnt_o = '0;
`endif
endmodule

// File: doc/wb_port_scheduler.md
# wb_port_scheduler

Arbitrates the single register-file write port between the MEM stage, the fixed-latency multi-cycle EX pipeline and the single-cycle ALU. EX writebacks are reserved at issue in a shift register, so a port conflict is known one cycle ahead. The block produces `ex_allowed_wb_o`, `alu_allowed_wb_o` and `wb_is_next_cycle_o`, which the hazard unit consumes to stall and bubble stages. It also drives the register-file write port.

## Interface
- `EX_LATENCY`, default 5: cycles from EX issue to EX writeback, with no freeze; legal range 2..8.
- `REGISTER_WIDTH`, default `params_pkg::REGISTER_WIDTH`: width of a register index.

Ports:
- `clk_i` input, 1 bit: clock; single clock domain.
- `rst_i` input, 1 bit: asynchronous, active-high reset.
- `ex_issue_i` input, 1 bit: an EX instruction enters ex1 this cycle.
- `ex_issue_wr_reg_i` input, `REGISTER_WIDTH` bits: destination of the issuing EX instruction.
- `mem_wb_req_i` input, 1 bit: MEM has a result to write this cycle.
- `mem_wr_reg_i` input, `REGISTER_WIDTH` bits: MEM destination.
- `alu_wb_req_i` input, 1 bit: ALU has a result to write this cycle.
- `alu_wr_reg_i` input, `REGISTER_WIDTH` bits: ALU destination.
- `ex_allowed_wb_o` output, 1 bit: the EX slot-0 result may write this cycle.
- `alu_allowed_wb_o` output, 1 bit: an ALU write would be granted this cycle.
- `wb_is_next_cycle_o` output, 1 bit: an EX writeback is reserved for the next cycle.
- `rf_wr_en_o` output, 1 bit: register-file write enable.
- `rf_wr_reg_o` output, `REGISTER_WIDTH` bits: register-file write index.
- `rf_wr_src_o` output, 2 bits: write source; 0 = none, 1 = MEM, 2 = EX, 3 = ALU.
- `err_o` output, 1 bit: sticky protocol-error flag.
- `ex_conflict_cnt_o` output, 32 bits: statistics counter (see Configuration).
- `alu_conflict_cnt_o` output, 32 bits: statistics counter (see Configuration).

## Operation
State:
- `res_q[EX_LATENCY-1:0]`: reservation bits.
- `reg_q[EX_LATENCY-1:0]`: the destination register held for each slot.
- `err_q`: sticky error flag.

Slot 0 means "EX writes back this cycle".

Grant priority is MEM > EX > ALU:
- `ex_allowed_wb_o` = `res_q[0] & !mem_wb_req_i`.
- `alu_allowed_wb_o` = `!mem_wb_req_i & !res_q[0]`.
- `freeze` = `res_q[0] & mem_wb_req_i`. A freeze stalls the whole EX pipeline, so every slot holds its value.

Write-port mux:
- MEM wins if requested.
- Otherwise EX wins if `res_q[0]` is set.
- Otherwise ALU wins if `alu_wb_req_i` is set.
- `rf_wr_en_o` is the OR of the granted requests. `rf_wr_reg_o` and `rf_wr_src_o` follow the winner. `rf_wr_reg_o` is 0 when no source wins.

Per clock edge:
- If frozen: `res_q` and `reg_q` hold.
- Otherwise: shift one slot down; slot 0 is dropped; slot `EX_LATENCY-1` loads `ex_issue_i` and `ex_issue_wr_reg_i`.

`wb_is_next_cycle_o`:
- = `res_q[1]` when not frozen.
- = `res_q[0]` when frozen, because the stalled EX result retries next cycle.

Protocol errors:
- `ex_issue_i` during a freeze is ignored and sets `err_q`. The hazard unit must bubble EX while it is stalled.
- `alu_wb_req_i` while `alu_allowed_wb_o`=0 is not an error. The ALU holds its result and retries.
- `err_o` clears only on reset.

## Timing
- Reset (asynchronous): `res_q`, `reg_q`, `err_q` and both counters are cleared to 0.
- Outputs during and after reset:
  - `ex_allowed_wb_o`=0, `wb_is_next_cycle_o`=0, `err_o`=0.
  - `alu_allowed_wb_o` = `!mem_wb_req_i`.
  - `rf_*` reflect only the MEM/ALU inputs.
- Reset mid-operation discards all reservations. Upstream pipelines are flushed by the same reset.
- Issue latency: `ex_issue_i` in cycle t gives `res_q[0]`=1 in cycle t+`EX_LATENCY`, plus one cycle for each freeze cycle in between. `wb_is_next_cycle_o`=1 in cycle t+`EX_LATENCY`-1.
- All grant and `rf_*` outputs are combinational from the inputs and current state; there is no output register. There are no combinational paths from `ex_issue_i` or `ex_issue_wr_reg_i` to any output.
- Back-to-back issues every cycle fill every slot. A single freeze delays every reservation by exactly one cycle.
- Issue in the same cycle that slot 0 retires and not frozen: both happen.

## Configuration
`WB_SCHED_STATS_EN`:
- Defined:
  - `ex_conflict_cnt_o` increments each freeze cycle.
  - `alu_conflict_cnt_o` increments each cycle `alu_wb_req_i & !alu_allowed_wb_o`.
  - Both are 32-bit and saturate at 0xFFFF_FFFF; reset clears them.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

## Test plan
- Reset, then `ex_issue_i`=1 with reg 7 at cycle 0, no other traffic: `wb_is_next_cycle_o`=1 at cycle 4, then at cycle 5 `rf_wr_en_o`=1, `rf_wr_reg_o`=7, `rf_wr_src_o`=2.
- Same issue, plus `mem_wb_req_i` with reg 3 at cycle 5: cycle 5 writes reg 3 (src 1) with `ex_allowed_wb_o`=0; cycle 6 writes reg 7 (src 2); `ex_conflict_cnt_o`=1 when stats are enabled.
- Issues with regs 1..5 on consecutive cycles: writes to regs 1..5 on cycles 5..9 with no gaps; `alu_allowed_wb_o`=0 on cycles 5..9.
- `alu_wb_req_i` with reg 9 while `res_q[0]`=1: `alu_allowed_wb_o`=0, EX wins. Next idle cycle: reg 9 written, src 3.
- `ex_issue_i` during a freeze: `err_o` rises next cycle and stays high; no reservation is added.
- Assert `rst_i` with three reservations pending: all `res_q` bits are 0 immediately and no EX write occurs afterwards.
